left_packetizer: RTL and testbench

- Upstream stage of the receiver-side elastic FIFO. Its output channel connects directly to that FIFO's data_right/vld_right/rdy_right.
- Groups an incoming word stream into fixed-length packets: one header word, then PKT_LEN payload words, then one checksum word.
- All three word types travel over a single valid/ready channel through a registered output slot.

---
 rtl/left_pkt_pkg.sv | 27 ++
 rtl/pkt_out_slot.sv | 38 +++
 rtl/left_packetizer.sv | 118 +++++++++++
 tb/tb_left_packetizer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/left_pkt_pkg.sv
// Shared types and helpers for the left-side packetizer.
//   state_t     : packetizer FSM states
//   HDR_TAG_DEF : default tag placed in the top byte of every header word
//   mk_header   : builds a header word {tag, zeros, seq} for a given data width
package left_pkt_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAY,
    S_SUM
  } state_t;

  localparam logic [7:0] HDR_TAG_DEF = 8'hA5;

  // Widest data path mk_header can build for; callers cast down to their DW.
  localparam int MAX_DW = 64;

  function automatic logic [MAX_DW-1:0] mk_header(input logic [7:0] tag,
                                                  input logic [7:0] seq,
                                                  input int         dw);
    logic [MAX_DW-1:0] h;
    h = MAX_DW'(seq);
    h = h | (MAX_DW'(tag) << (dw - 8));
    return h;
  endfunction

endpackage

// File: rtl/pkt_out_slot.sv
// Single-entry valid/ready output register.
//   load/din   : write din into the slot this cycle (only when slot_free)
//   rdy_left   : downstream ready
//   data_left  : held word, stable while vld_left & ~rdy_left
//   vld_left   : slot holds a word
//   slot_free  : slot is empty or is being drained this cycle
module pkt_out_slot #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          rdy_left,
  output logic [DW-1:0] data_left,
  output logic          vld_left,
  output logic          slot_free
);

  assign slot_free = ~vld_left | rdy_left;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_left  <= 1'b0;
      // NOTE: the data register is reset too, so data_left is a known zero
      // out of reset rather than whatever the flops powered up with.
      data_left <= '0;
    end else if (load) begin
      vld_left  <= 1'b1;
      data_left <= din;
    end else if (slot_free) begin
      vld_left  <= 1'b0;
    end
  end

endmodule

// File: rtl/left_packetizer.sv
// Groups an input word stream into packets: header, PKT_LEN payload words,
// checksum. All words leave through one registered valid/ready slot.
//   data_i/valid_i/ready_o : source channel (ready_o never depends on valid_i)
//   data_left/vld_left/rdy_left : output channel to the downstream FIFO
//   busy_o    : a packet is in progress
//   pkt_cnt_o : completed packets, wraps at 2^16
// DW must be in 16..64.
module left_packetizer
  import left_pkt_pkg::*;
#(
  parameter int         DW      = 16,
  parameter int         PKT_LEN = 4,
  parameter logic [7:0] HDR_TAG = HDR_TAG_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [DW-1:0] data_left,
  output logic          vld_left,
  input  logic          rdy_left,
  output logic          busy_o,
  output logic [15:0]   pkt_cnt_o
);

  localparam int CNT_W = $clog2(PKT_LEN + 1);

  state_t           state, state_n;
  logic [7:0]       seq;
  logic [DW-1:0]    csum;
  logic [CNT_W-1:0] count;
  logic [15:0]      pkt_cnt;

  logic             slot_free;
  logic             load;
  logic [DW-1:0]    load_data;
  logic [DW-1:0]    header;
  logic             hdr_go, pay_acc, sum_go;

  assign header    = DW'(mk_header(HDR_TAG, seq, DW));
  assign ready_o   = (state == S_PAY) && slot_free;
  assign busy_o    = (state != S_IDLE);
  assign pkt_cnt_o = pkt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_n   = state;
    load      = 1'b0;
    load_data = '0;
    hdr_go    = 1'b0;
    pay_acc   = 1'b0;
    sum_go    = 1'b0;
    unique case (state)
      // The header is emitted on valid_i alone; the first data word is
      // consumed a cycle later in S_PAY.
      S_IDLE: if (valid_i && slot_free) begin
        hdr_go    = 1'b1;
        load      = 1'b1;
        load_data = header;
        state_n   = S_PAY;
      end
      S_PAY: if (valid_i && ready_o) begin
        pay_acc   = 1'b1;
        load      = 1'b1;
        load_data = data_i;
        if (count == CNT_W'(PKT_LEN - 1)) state_n = S_SUM;
      end
      S_SUM: if (slot_free) begin
        sum_go    = 1'b1;
        load      = 1'b1;
        load_data = csum;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Checksum seeds with the header and accumulates modulo 2^DW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq     <= '0;
      csum    <= '0;
      count   <= '0;
      pkt_cnt <= '0;
    end else begin
      if (hdr_go) begin
        csum  <= header;
        count <= '0;
      end else if (pay_acc) begin
        csum  <= csum + data_i;
        count <= count + 1'b1;
      end
      if (sum_go) begin
        seq     <= seq + 8'd1;
        pkt_cnt <= pkt_cnt + 16'd1;
      end
    end
  end

  pkt_out_slot #(.DW(DW)) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .din       (load_data),
    .rdy_left  (rdy_left),
    .data_left (data_left),
    .vld_left  (vld_left),
    .slot_free (slot_free)
  );

endmodule

// File: tb/tb_left_packetizer.sv
// Self-checking bench for left_packetizer (DW=16, PKT_LEN=4, tag 0xA5).
// Expected output words are queued when a packet is driven and compared by a
// monitor as each word transfers downstream.
module tb_left_packetizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] data_left;
  logic        vld_left;
  logic        rdy_left;
  logic        busy_o;
  logic [15:0] pkt_cnt_o;

  int          total = 0;
  int          bad   = 0;

  logic [15:0] exp_q [$];
  logic [7:0]  m_seq  = 8'd0;
  int          m_pkts = 0;
  logic [15:0] pay [4];

  int          run_len   = 0;
  int          max_run   = 0;
  bit          prev_xfer = 1'b0;

  left_packetizer #(.DW(16), .PKT_LEN(4), .HDR_TAG(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_left (data_left),
    .vld_left  (vld_left),
    .rdy_left  (rdy_left),
    .busy_o    (busy_o),
    .pkt_cnt_o (pkt_cnt_o)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: a word transfers on the next rising edge whenever
  // vld_left & rdy_left hold at the falling edge.
  always @(negedge clk) begin : mon
    logic [15:0] e;
    if (rst_n && vld_left && rdy_left) begin
      run_len   = prev_xfer ? run_len + 1 : 1;
      if (run_len > max_run) max_run = run_len;
      prev_xfer = 1'b1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_word: got %h, nothing expected", data_left);
      end else begin
        e = exp_q.pop_front();
        if (data_left !== e) begin
          bad++;
          $display("FAIL out_word: got %h, expected %h", data_left, e);
        end
      end
    end else begin
      prev_xfer = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_accept();
    bit ok = 1'b0;
    int n  = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (ready_o) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
      n++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: ready_o never rose for data %h", data_i);
    end
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    int n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !vld_left) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
    end
  endtask

  task automatic apply_reset();
    valid_i = 1'b0;
    data_i  = 16'h0;
    rdy_left = 1'b1;
    rst_n   = 1'b0;
    exp_q.delete();
    m_seq   = 8'd0;
    m_pkts  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_cnt(input string name);
    total++;
    if (pkt_cnt_o !== 16'(m_pkts)) begin
      bad++;
      $display("FAIL %s: pkt_cnt_o=%0d expected %0d", name, pkt_cnt_o, m_pkts);
    end
  endtask

  // Queue the expected packet, then drive its payload. stall_idx >= 0 holds
  // rdy_left low for 5 cycles right after that payload word is loaded; gap
  // inserts idle input cycles between payload words.
  task automatic send_packet(input int stall_idx, input int gap);
    logic [15:0] s;
    s = {8'hA5, m_seq};
    exp_q.push_back(s);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pay[i]);
      s = s + pay[i];
    end
    exp_q.push_back(s);
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1;
      data_i  = pay[i];
      wait_accept();
      if (i == stall_idx) begin
        rdy_left = 1'b0;
        if (i < 3) data_i = pay[i+1];
        repeat (5) begin
          @(negedge clk);
          total++;
          if (data_left !== pay[i] || vld_left !== 1'b1 || ready_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold: data_left=%h vld_left=%b ready_o=%b expected %h 1 0",
                     data_left, vld_left, ready_o, pay[i]);
          end
        end
        @(posedge clk);
        #1;
        rdy_left = 1'b1;
      end
      if (gap > 0 && i < 3) begin
        valid_i = 1'b0;
        data_i  = 16'hDEAD;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    valid_i = 1'b0;
    data_i  = 16'hBEEF;
    m_seq   = m_seq + 8'd1;
    m_pkts++;
  endtask

  task automatic test_reset();
    valid_i  = 1'b0;
    data_i   = 16'h0;
    rdy_left = 1'b1;
    rst_n    = 1'b0;
    #3;
    total++;
    if (vld_left !== 1'b0 || data_left !== 16'h0 || busy_o !== 1'b0 ||
        pkt_cnt_o !== 16'h0 || ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: vld=%b data=%h busy=%b cnt=%0d rdy=%b expected 0 0000 0 0 0",
               vld_left, data_left, busy_o, pkt_cnt_o, ready_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) pay[i] = 16'(i + 1);
    max_run = 0;
    send_packet(-1, 0);
    wait_drain();
    total++;
    if (max_run !== 6) begin
      bad++;
      $display("FAIL basic_contiguous: longest output run=%0d expected 6", max_run);
    end
    check_cnt("basic_pkt_cnt");
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle: busy_o=%b expected 0", busy_o);
    end
  endtask

  task automatic test_reset_mid();
    pay[0] = 16'h1111;
    pay[1] = 16'h2222;
    exp_q.push_back({8'hA5, m_seq});
    exp_q.push_back(pay[0]);
    valid_i = 1'b1;
    data_i  = pay[0];
    wait_accept();
    data_i  = pay[1];
    wait_accept();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (vld_left !== 1'b0 || busy_o !== 1'b0 || pkt_cnt_o !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid: vld=%b busy=%b cnt=%0d expected 0 0 0",
               vld_left, busy_o, pkt_cnt_o);
    end
    valid_i = 1'b0;
    exp_q.delete();
    m_seq  = 8'd0;
    m_pkts = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) pay[i] = 16'h0100 + 16'(i);
    send_packet(-1, 0);
    wait_drain();
    check_cnt("reset_mid_pkt_cnt");
  endtask

  task automatic test_csum_wrap();
    apply_reset();
    for (int i = 0; i < 4; i++) pay[i] = 16'hFFFF;
    send_packet(-1, 0);
    wait_drain();
    check_cnt("csum_wrap_pkt_cnt");
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) pay[i] = 16'(i + 1);
    send_packet(1, 0);
    wait_drain();
    check_cnt("backpressure_pkt_cnt");
  endtask

  task automatic test_sparse();
    for (int i = 0; i < 4; i++) pay[i] = 16'(i + 1);
    send_packet(-1, 2);
    wait_drain();
    check_cnt("sparse_pkt_cnt");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    max_run = 0;
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 4; i++) pay[i] = 16'($urandom);
      send_packet(-1, 0);
    end
    wait_drain();
    check_cnt("seq_wrap_pkt_cnt");
    total++;
    if (max_run !== 256 * 6) begin
      bad++;
      $display("FAIL back_to_back_gap: longest output run=%0d expected %0d", max_run, 256 * 6);
    end
    for (int i = 0; i < 4; i++) pay[i] = 16'h0A0A + 16'(i);
    send_packet(-1, 0);
    wait_drain();
    check_cnt("seq_wrap_next_pkt_cnt");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_csum_wrap();
    test_backpressure();
    test_sparse();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
